dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory bus. It services load and store requests issued from the core's MEM stage.
- Backed by an internal word-organised RAM of DMEM_DEPTH words.
- Formats sub-word loads and stores by the funct3 op code, inserts configurable wait states, and holds the pipeline through stall_pipl until the access completes.
- Flags misaligned accesses instead of performing them.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind the core's MEM-stage bus,
// with sub-word load/store formatting, wait-state insertion and misalignment flagging.
module dmem_responder #(
    parameter int DMEM_DEPTH  = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        misaligned_err,
    output logic [1:0]  state_dbg
);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          mis_q;
    logic [31:0]   ram [DMEM_DEPTH];

    logic          req;
    logic          accept;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   wdata_lanes;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic          misaligned;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          unused_addr_bits;

    // Handshake: a request is any cycle with read or write high in IDLE. stall_pipl
    // holds the core (inputs stable) until RESP, where stall drops and rdata is sampled.
    assign req              = mem_read_mem | mem_write_mem;
    assign accept           = reset_n && (state == S_IDLE) && req;
    assign idx              = mem_addr_mem[AW+1:2];
    assign word             = ram[idx];
    assign unused_addr_bits = ^mem_addr_mem[31:AW+2];

    // Lane selection, write enables and load extension derived from funct3.
    always_comb begin
        misaligned  = 1'b0;
        be          = 4'b0000;
        wdata_lanes = mem_wdata_mem;
        load_data   = word;
        sel_byte    = word[{mem_addr_mem[1:0], 3'b000} +: 8];
        sel_half    = word[{mem_addr_mem[1], 4'b0000} +: 16];
        if (mem_op_mem[1:0] == 2'b00) begin
            be          = 4'b0001 << mem_addr_mem[1:0];
            wdata_lanes = {4{mem_wdata_mem[7:0]}};
            load_data   = {{24{sel_byte[7] & ~mem_op_mem[2]}}, sel_byte};
        end else if (mem_op_mem[1:0] == 2'b01) begin
            misaligned  = mem_addr_mem[0];
            be          = mem_addr_mem[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{mem_wdata_mem[15:0]}};
            load_data   = {{16{sel_half[15] & ~mem_op_mem[2]}}, sel_half};
        end else begin
            misaligned  = (mem_addr_mem[1:0] != 2'b00);
            be          = 4'b1111;
        end
        if (misaligned) begin
            be        = 4'b0000;
            load_data = '0;
        end
    end

    // RAM is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (accept && mem_write_mem) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            mis_q         <= 1'b0;
            mem_rdata_mem <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                mis_q <= misaligned;
                if (mem_read_mem) begin
                    mem_rdata_mem <= mem_write_mem ? 32'd0 : load_data;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end else begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign stall_pipl     = reset_n && (((state == S_IDLE) && req) || (state == S_WAIT));
    assign misaligned_err = reset_n && (state == S_RESP) && mis_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states, one with three,
// driven by directed accesses and checked by a per-instance response scoreboard.
module tb_dmem_responder;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam int         BUDGET = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_s [2];
    logic [31:0] wdata_s [2];
    logic        wr_s [2];
    logic        rd_s [2];
    logic [2:0]  op_s [2];
    logic [31:0] rdata_o [2];
    logic        stall_o [2];
    logic        mis_o [2];
    logic [1:0]  st_o [2];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_done;
    int t0;
    int run [2];
    int stall_len [2];
    logic [41:0] exp_q0 [$];
    logic [41:0] exp_q1 [$];
    logic [41:0] e;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        stall_len[0] = 1;
        stall_len[1] = 4;
        run[0] = 0;
        run[1] = 0;
    end

    dmem_responder #(.DMEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(rst_n),
        .mem_addr_mem(addr_s[0]), .mem_wdata_mem(wdata_s[0]),
        .mem_write_mem(wr_s[0]), .mem_read_mem(rd_s[0]), .mem_op_mem(op_s[0]),
        .mem_rdata_mem(rdata_o[0]), .stall_pipl(stall_o[0]),
        .misaligned_err(mis_o[0]), .state_dbg(st_o[0])
    );

    dmem_responder #(.DMEM_DEPTH(1024), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset_n(rst_n),
        .mem_addr_mem(addr_s[1]), .mem_wdata_mem(wdata_s[1]),
        .mem_write_mem(wr_s[1]), .mem_read_mem(rd_s[1]), .mem_op_mem(op_s[1]),
        .mem_rdata_mem(rdata_o[1]), .stall_pipl(stall_o[1]),
        .misaligned_err(mis_o[1]), .state_dbg(st_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver: called one time unit after a clock edge; returns in the RESP cycle
    task automatic access(input int d, input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic chk, input logic [31:0] exp_rd, input logic exp_mis);
        int   n;
        logic seen;
        logic [41:0] ent;
        ent = {chk, exp_mis, 8'(stall_len[d]), exp_rd};
        if (d == 0) exp_q0.push_back(ent);
        else        exp_q1.push_back(ent);
        rd_s[d] = rd; wr_s[d] = wr; op_s[d] = op; addr_s[d] = addr; wdata_s[d] = wdata;
        #1;
        seen = stall_o[d];
        n = 0;
        while (n < BUDGET && !(seen && !stall_o[d])) begin
            @(posedge clk); #1;
            if (stall_o[d]) seen = 1'b1;
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            fails++;
            $display("FAIL access_timeout dut%0d addr 0x%08h: no completion in %0d cycles", d, addr, BUDGET);
        end
        last_done = cyc;
    endtask

    task automatic idle(input int d);
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
    endtask

    // Monitor: a response is the first non-stalled cycle after a stall run
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                run[d] = 0;
                checks++;
                if (mis_o[d] !== 1'b0 || stall_o[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_outputs dut%0d: stall %b err %b, expected 0 0", d, stall_o[d], mis_o[d]);
                end
            end else if (stall_o[d]) begin
                run[d]++;
            end else if (run[d] > 0) begin
                if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp dut%0d: response with empty queue", d);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("stall_cycles_dut%0d", d), 32'(run[d]), 32'(e[39:32]));
                    check($sformatf("misaligned_err_dut%0d", d), 32'(mis_o[d]), 32'(e[40]));
                    if (e[41]) check($sformatf("rdata_dut%0d", d), rdata_o[d], e[31:0]);
                end
                run[d] = 0;
            end else begin
                checks++;
                if (mis_o[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL spurious_err dut%0d: misaligned_err %b outside response, expected 0", d, mis_o[d]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr_s[d] = '0; wdata_s[d] = '0; wr_s[d] = 1'b0; rd_s[d] = 1'b0; op_s[d] = OP_W;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_rdata_dut%0d", d), rdata_o[d], 32'd0);
            check($sformatf("reset_state_dut%0d", d), 32'(st_o[d]), 32'd0);
            check($sformatf("reset_stall_dut%0d", d), 32'(stall_o[d]), 32'd0);
        end
        @(posedge clk); #1;

        // No wait states: word, sub-word, misaligned, read+write, aliasing
        access(0, 0, 1, OP_W,  32'h100, 32'hDEADBEEF, 0, 32'h0, 0);
        t0 = last_done;
        access(0, 1, 0, OP_W,  32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
        check("b2b_period_ws0", 32'(last_done - t0), 32'd2);
        access(0, 1, 0, OP_B,  32'h101, 32'h0, 1, 32'hFFFFFFBE, 0);
        access(0, 1, 0, OP_BU, 32'h101, 32'h0, 1, 32'h000000BE, 0);
        access(0, 1, 0, OP_H,  32'h102, 32'h0, 1, 32'hFFFFDEAD, 0);
        access(0, 1, 0, OP_HU, 32'h102, 32'h0, 1, 32'h0000DEAD, 0);
        access(0, 0, 1, OP_B,  32'h103, 32'h00000055, 0, 32'h0, 0);
        access(0, 1, 0, OP_W,  32'h100, 32'h0, 1, 32'h55ADBEEF, 0);
        access(0, 0, 1, OP_W,  32'h102, 32'h12345678, 1, 32'h55ADBEEF, 1);
        access(0, 1, 0, OP_W,  32'h100, 32'h0, 1, 32'h55ADBEEF, 0);
        access(0, 1, 0, OP_H,  32'h101, 32'h0, 1, 32'h00000000, 1);
        access(0, 1, 1, OP_W,  32'h104, 32'h11223344, 1, 32'h00000000, 0);
        access(0, 1, 0, OP_W,  32'h104, 32'h0, 1, 32'h11223344, 0);
        access(0, 0, 1, OP_H,  32'h106, 32'h00008001, 0, 32'h0, 0);
        access(0, 1, 0, OP_H,  32'h106, 32'h0, 1, 32'hFFFF8001, 0);
        access(0, 1, 0, OP_B,  32'h104, 32'h0, 1, 32'h00000044, 0);
        access(0, 1, 0, 3'b011, 32'h104, 32'h0, 1, 32'h80013344, 0);
        access(0, 0, 1, OP_W,  32'h1004, 32'hA5A5A5A5, 0, 32'h0, 0);
        access(0, 1, 0, OP_W,  32'h0004, 32'h0, 1, 32'hA5A5A5A5, 0);
        idle(0);

        // Three wait states: stall length, back-to-back period, misaligned
        access(1, 0, 1, OP_W,  32'h100, 32'hDEADBEEF, 0, 32'h0, 0);
        access(1, 1, 0, OP_W,  32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
        t0 = last_done;
        access(1, 1, 0, OP_BU, 32'h103, 32'h0, 1, 32'h000000DE, 0);
        check("b2b_period_ws3", 32'(last_done - t0), 32'd5);
        access(1, 1, 0, OP_W,  32'h101, 32'h0, 1, 32'h00000000, 1);

        // Reset while the store to 0x200 is in WAIT
        idle(1);
        @(posedge clk); #1;
        rd_s[1] = 1'b0; wr_s[1] = 1'b1; op_s[1] = OP_W; addr_s[1] = 32'h200; wdata_s[1] = 32'hCAFEF00D;
        #1;
        check("abort_stall_idle", 32'(stall_o[1]), 32'd1);
        @(posedge clk); #1;
        check("abort_in_wait", 32'(st_o[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_stall_forced", 32'(stall_o[1]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        #1;
        check("abort_state", 32'(st_o[1]), 32'd0);
        check("abort_stall", 32'(stall_o[1]), 32'd0);
        check("abort_err", 32'(mis_o[1]), 32'd0);
        check("abort_rdata", rdata_o[1], 32'd0);
        @(posedge clk); #1;
        access(1, 1, 0, OP_W,  32'h200, 32'h0, 1, 32'hCAFEF00D, 0);
        idle(1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain_dut0", 32'(exp_q0.size()), 32'd0);
        check("sb_drain_dut1", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
